// File: rtl/prot_err_pkg.sv
// Shared definitions for the AFU TX protocol error capture block.
// Holds the error-bit positions reported by the protocol checker,
// the number of error sources and the capture FSM state type.
package prot_err_pkg;

    localparam int MALFORMED_TLP = 0;
    localparam int MAX_PAYLOAD   = 1;
    localparam int MAX_RD_REQ    = 2;
    localparam int MWR_INSUFF    = 3;
    localparam int MWR_OVERRUN   = 4;
    localparam int MMIO_INSUFF   = 5;
    localparam int MMIO_OVERRUN  = 6;
    localparam int MAX_TAG       = 7;
    localparam int MMIO_RD_RST   = 8;
    localparam int MMIO_WR_RST   = 9;

    localparam int NUM_PROT_ERR  = 10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INTR_PEND = 2'd1,
        ST_BLOCKED   = 2'd2
    } prot_err_state_e;

endpackage

// File: rtl/prot_err_capture.sv
// Protocol error capture for the port TX path.
// Collects single-cycle error pulses from the TX protocol checker into a
// sticky status register, records the first error (bits, VF, timestamp),
// counts error cycles (saturating), blocks AFU traffic and raises an
// interrupt to the FME until software acknowledges and clears the status.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_err_vec         error pulses from the protocol checker
//   i_vf_num          VF number accompanying the pulse (0 = PF)
//   i_err_mask        static mask, 1 = ignore that error bit
//   i_csr_clr_valid   CSR write strobe for write-1-to-clear
//   i_csr_clr_mask    bits to clear in the sticky status
//   i_intr_ack        interrupt acknowledge from the FME
//   o_err_sticky      sticky error status
//   o_first_err_vec   unmasked error bits of the first error cycle
//   o_first_vf_num    VF number of the first error
//   o_first_err_ts    timestamp of the first error
//   o_err_cnt         saturating count of error cycles
//   o_block_traffic   drop AFU TX traffic while set
//   o_intr_req        level interrupt request
//
// state        | meaning
// ST_IDLE      | no outstanding error, traffic flows
// ST_INTR_PEND | error captured, interrupt raised, traffic blocked
// ST_BLOCKED   | interrupt acknowledged, waiting for status to be cleared
module prot_err_capture
    import prot_err_pkg::*;
#(
    parameter int NUM_ERR = NUM_PROT_ERR,
    parameter int TS_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_ERR-1:0] i_err_vec,
    input  logic [10:0]        i_vf_num,
    input  logic [NUM_ERR-1:0] i_err_mask,
    input  logic               i_csr_clr_valid,
    input  logic [NUM_ERR-1:0] i_csr_clr_mask,
    input  logic               i_intr_ack,
    output logic [NUM_ERR-1:0] o_err_sticky,
    output logic [NUM_ERR-1:0] o_first_err_vec,
    output logic [10:0]        o_first_vf_num,
    output logic [TS_W-1:0]    o_first_err_ts,
    output logic [CNT_W-1:0]   o_err_cnt,
    output logic               o_block_traffic,
    output logic               o_intr_req
);

    logic [NUM_ERR-1:0] w_eff_err;
    logic               w_err_event;
    logic [NUM_ERR-1:0] w_clr;
    logic [NUM_ERR-1:0] w_sticky_nxt;

    logic [TS_W-1:0]    r_ts;
    logic [NUM_ERR-1:0] r_err_sticky;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [NUM_ERR-1:0] r_first_err_vec;
    logic [10:0]        r_first_vf_num;
    logic [TS_W-1:0]    r_first_err_ts;
    logic               r_block_traffic;
    logic               r_intr_req;
    prot_err_state_e    r_state;

    assign w_eff_err    = i_err_vec & ~i_err_mask;
    assign w_err_event  = |w_eff_err;
    assign w_clr        = i_csr_clr_valid ? i_csr_clr_mask : '0;
    // New errors are OR'd in after the clear, so a set wins over a clear.
    assign w_sticky_nxt = (r_err_sticky & ~w_clr) | w_eff_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts         <= '0;
            r_err_sticky <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_ts         <= r_ts + TS_W'(1);
            r_err_sticky <= w_sticky_nxt;
            if (w_err_event && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_first_err_vec <= '0;
            r_first_vf_num  <= '0;
            r_first_err_ts  <= '0;
            r_block_traffic <= 1'b0;
            r_intr_req      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_err_event) begin
                        r_first_err_vec <= w_eff_err;
                        r_first_vf_num  <= i_vf_num;
                        r_first_err_ts  <= r_ts;
                        r_block_traffic <= 1'b1;
                        r_intr_req      <= 1'b1;
                        r_state         <= ST_INTR_PEND;
                    end
                end
                ST_INTR_PEND: begin
                    if (i_intr_ack) begin
                        r_intr_req <= 1'b0;
                        r_state    <= ST_BLOCKED;
                    end
                end
                ST_BLOCKED: begin
                    // Leave only once software has cleared every sticky bit
                    // and nothing new arrived in the same cycle.
                    if ((w_sticky_nxt == '0) && !w_err_event) begin
                        r_first_err_vec <= '0;
                        r_first_vf_num  <= '0;
                        r_first_err_ts  <= '0;
                        r_block_traffic <= 1'b0;
                        r_state         <= ST_IDLE;
                    end
                end
                default: begin
                    r_block_traffic <= 1'b0;
                    r_intr_req      <= 1'b0;
                    r_state         <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_err_sticky    = r_err_sticky;
    assign o_first_err_vec = r_first_err_vec;
    assign o_first_vf_num  = r_first_vf_num;
    assign o_first_err_ts  = r_first_err_ts;
    assign o_err_cnt       = r_err_cnt;
    assign o_block_traffic = r_block_traffic;
    assign o_intr_req      = r_intr_req;

endmodule

// File: tb/tb_prot_err_capture.sv
// Randomized self-checking bench for prot_err_capture with a behavioural
// reference model, plus directed scenarios with hand-computed values.
module tb_prot_err_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  err_vec = '0;
    logic [10:0] vf_num = '0;
    logic [9:0]  err_mask = '0;
    logic        clr_valid = 1'b0;
    logic [9:0]  clr_mask = '0;
    logic        intr_ack = 1'b0;

    logic [9:0]  o_err_sticky;
    logic [9:0]  o_first_err_vec;
    logic [10:0] o_first_vf_num;
    logic [31:0] o_first_err_ts;
    logic [15:0] o_err_cnt;
    logic        o_block_traffic;
    logic        o_intr_req;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    prot_err_capture dut (
        .clk             (clk),
        .rst             (rst),
        .i_err_vec       (err_vec),
        .i_vf_num        (vf_num),
        .i_err_mask      (err_mask),
        .i_csr_clr_valid (clr_valid),
        .i_csr_clr_mask  (clr_mask),
        .i_intr_ack      (intr_ack),
        .o_err_sticky    (o_err_sticky),
        .o_first_err_vec (o_first_err_vec),
        .o_first_vf_num  (o_first_vf_num),
        .o_first_err_ts  (o_first_err_ts),
        .o_err_cnt       (o_err_cnt),
        .o_block_traffic (o_block_traffic),
        .o_intr_req      (o_intr_req)
    );

    // Reference model: an "interrupt outstanding" flag and a "blocked" flag
    // describe the whole protocol; the rest is plain arithmetic.
    logic [9:0]  m_sticky;
    int          m_cnt;
    logic [31:0] m_ts;
    logic [9:0]  m_fvec;
    logic [10:0] m_fvf;
    logic [31:0] m_fts;
    bit          m_irq;
    bit          m_blk;

    wire [9:0] m_eff     = err_vec & ~err_mask;
    wire       m_ev      = (m_eff != 10'd0);
    wire [9:0] m_nsticky = (m_sticky & ~(clr_valid ? clr_mask : 10'd0)) | m_eff;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sticky <= '0; m_cnt <= 0; m_ts <= '0;
            m_fvec <= '0; m_fvf <= '0; m_fts <= '0;
            m_irq <= 1'b0; m_blk <= 1'b0;
        end else begin
            m_ts     <= m_ts + 32'd1;
            m_sticky <= m_nsticky;
            if (m_ev && m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (!m_blk) begin
                if (m_ev) begin
                    m_fvec <= m_eff; m_fvf <= vf_num; m_fts <= m_ts;
                    m_irq <= 1'b1; m_blk <= 1'b1;
                end
            end else if (m_irq) begin
                if (intr_ack) m_irq <= 1'b0;
            end else if (m_nsticky == 10'd0 && !m_ev) begin
                m_blk <= 1'b0;
                m_fvec <= '0; m_fvf <= '0; m_fts <= '0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_sticky", 32'(o_err_sticky),    32'(m_sticky));
            chk("m_fvec",   32'(o_first_err_vec), 32'(m_fvec));
            chk("m_fvf",    32'(o_first_vf_num),  32'(m_fvf));
            chk("m_fts",    o_first_err_ts,       m_fts);
            chk("m_cnt",    32'(o_err_cnt),       32'(m_cnt));
            chk("m_block",  32'(o_block_traffic), 32'(m_blk));
            chk("m_intr",   32'(o_intr_req),      32'(m_irq));
        end
    end

    task automatic idle_inputs();
        err_vec = '0; vf_num = '0; clr_valid = 1'b0; clr_mask = '0; intr_ack = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sticky"}, 32'(o_err_sticky), 32'h0);
        chk({tag, "_fvec"},   32'(o_first_err_vec), 32'h0);
        chk({tag, "_fvf"},    32'(o_first_vf_num), 32'h0);
        chk({tag, "_fts"},    o_first_err_ts, 32'h0);
        chk({tag, "_cnt"},    32'(o_err_cnt), 32'h0);
        chk({tag, "_block"},  32'(o_block_traffic), 32'h0);
        chk({tag, "_intr"},   32'(o_intr_req), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // First error at timestamp 0x64
        guard = 0;
        while (m_ts != 32'h64 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("ts_reach_timeout", 32'(guard < 500), 32'd1);
        err_vec = 10'h002; vf_num = 11'd5;
        step();
        chk("e1_sticky", 32'(o_err_sticky), 32'h002);
        chk("e1_fvf",    32'(o_first_vf_num), 32'd5);
        chk("e1_fts",    o_first_err_ts, 32'h64);
        chk("e1_cnt",    32'(o_err_cnt), 32'd1);
        chk("e1_intr",   32'(o_intr_req), 32'd1);
        chk("e1_block",  32'(o_block_traffic), 32'd1);

        // Second error, then acknowledge
        err_vec = 10'h080; vf_num = 11'd9;
        step();
        chk("e2_sticky", 32'(o_err_sticky), 32'h082);
        chk("e2_fvec",   32'(o_first_err_vec), 32'h002);
        chk("e2_fvf",    32'(o_first_vf_num), 32'd5);
        chk("e2_intr",   32'(o_intr_req), 32'd1);
        intr_ack = 1'b1;
        step();
        chk("ack_intr",  32'(o_intr_req), 32'd0);
        chk("ack_block", 32'(o_block_traffic), 32'd1);
        chk("ack_cnt",   32'(o_err_cnt), 32'd2);
        chk("ack_fts",   o_first_err_ts, 32'h64);

        // Partial, then full clear
        clr_valid = 1'b1; clr_mask = 10'h002;
        step();
        chk("pclr_sticky", 32'(o_err_sticky), 32'h080);
        chk("pclr_block",  32'(o_block_traffic), 32'd1);
        clr_valid = 1'b1; clr_mask = 10'h080;
        step();
        chk("fclr_sticky", 32'(o_err_sticky), 32'h000);
        chk("fclr_block",  32'(o_block_traffic), 32'd0);
        chk("fclr_fvec",   32'(o_first_err_vec), 32'h000);
        chk("fclr_fvf",    32'(o_first_vf_num), 32'd0);

        // Set/clear collision in BLOCKED
        err_vec = 10'h080; vf_num = 11'd3;
        step();
        intr_ack = 1'b1;
        step();
        clr_valid = 1'b1; clr_mask = 10'h080; err_vec = 10'h080;
        step();
        chk("coll_sticky", 32'(o_err_sticky), 32'h080);
        chk("coll_block",  32'(o_block_traffic), 32'd1);
        chk("coll_intr",   32'(o_intr_req), 32'd0);
        chk("coll_cnt",    32'(o_err_cnt), 32'd4);
        clr_valid = 1'b1; clr_mask = 10'h3FF;
        step();
        chk("coll_exit", 32'(o_block_traffic), 32'd0);

        // Masked and multi-bit errors
        do_reset();
        err_mask = 10'h001;
        err_vec = 10'h001;
        step();
        chk("mask_sticky", 32'(o_err_sticky), 32'h000);
        chk("mask_cnt",    32'(o_err_cnt), 32'd0);
        chk("mask_intr",   32'(o_intr_req), 32'd0);
        err_vec = 10'h3FF; vf_num = 11'h7FF;
        step();
        chk("multi_sticky", 32'(o_err_sticky), 32'h3FE);
        chk("multi_fvec",   32'(o_first_err_vec), 32'h3FE);
        chk("multi_fvf",    32'(o_first_vf_num), 32'h7FF);
        chk("multi_cnt",    32'(o_err_cnt), 32'd1);

        // Counter saturation with a continuous error stream
        for (int i = 0; i < 65540; i++) begin
            err_vec = 10'(1 << $urandom_range(1, 9));
            @(negedge clk);
        end
        idle_inputs();
        chk("sat_cnt",  32'(o_err_cnt), 32'hFFFF);
        chk("sat_intr", 32'(o_intr_req), 32'd1);
        step();
        chk("sat_hold", 32'(o_err_cnt), 32'hFFFF);

        // Asynchronous reset while the interrupt is pending
        #2 rst = 1'b1;
        #1 chk_all_zero("areset");
        @(negedge clk);
        rst = 1'b0;
        err_mask = '0;

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst       = 1'b0;
            err_vec   = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1, 1023)) : 10'd0;
            vf_num    = 11'($urandom_range(0, 2047));
            intr_ack  = ($urandom_range(0, 5) == 0);
            clr_valid = ($urandom_range(0, 3) == 0);
            clr_mask  = ($urandom_range(0, 1) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
            if (c % 250 == 0)
                err_mask = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'(1 << $urandom_range(0, 9));
            if ($urandom_range(0, 599) == 0) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/prot_err_capture.md
Name: prot_err_capture

Overview:
- Sits directly downstream of the AFU TX protocol checker in the port gasket.
- Consumes the checker's single-cycle error pulses and the offending VF number.
- Maintains sticky error status, first-error forensic record, saturating error count, and a timestamp.
- Drives the traffic-blocking control for the port TX path and an interrupt request to the FME, with CSR write-1-to-clear recovery.

Parameters:
NUM_ERR, 10, number of error pulse inputs, bit order fixed by prot_err_pkg.
TS_W, 32, free-running timestamp width.
CNT_W, 16, saturating error counter width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_err_vec  in  NUM_ERR  single-cycle error pulses from the protocol checker
i_vf_num  in  11  VF number accompanying the error pulse; 0 when the source is PF
i_err_mask  in  NUM_ERR  1 = ignore the corresponding error bit, static CSR value
i_csr_clr_valid  in  1  one-cycle CSR write strobe
i_csr_clr_mask  in  NUM_ERR  W1C mask applied to sticky bits when i_csr_clr_valid=1
i_intr_ack  in  1  interrupt acknowledge from the FME
o_err_sticky  out  NUM_ERR  sticky error status
o_first_err_vec  out  NUM_ERR  unmasked error bits seen in the first error cycle
o_first_vf_num  out  11  VF number captured with the first error
o_first_err_ts  out  TS_W  timestamp captured with the first error
o_err_cnt  out  CNT_W  count of cycles with at least one unmasked error, saturating
o_block_traffic  out  1  1 = port TX path must drop AFU traffic
o_intr_req  out  1  level interrupt request, held until acknowledged

Behaviour:
- Reset:
  - All outputs are 0.
  - The timestamp counter is 0.
  - The FSM is in IDLE.
- Event definitions:
  - eff_err = i_err_vec & ~i_err_mask.
  - An error event occurs when |eff_err = 1.
- Timestamp:
  - The counter increments every cycle and wraps from all-ones to 0.
- Sticky register:
  - Next value = (sticky & ~(clr_valid ? clr_mask : 0)) | eff_err.
  - Set dominates clear when both hit the same bit in the same cycle.
- Error counter:
  - Increments by 1 per error-event cycle, regardless of how many bits are set.
  - Holds at all-ones.
  - Clears only on rst.
- FSM states: IDLE, INTR_PEND, BLOCKED.
  - IDLE, on error event:
    - Capture first_err_vec = eff_err, first_vf_num = i_vf_num, first_err_ts = the current counter value.
    - Go to INTR_PEND.
  - INTR_PEND:
    - o_intr_req = 1 and o_block_traffic = 1.
    - On i_intr_ack, go to BLOCKED.
    - CSR clears are applied to sticky but do not leave the state.
  - BLOCKED:
    - o_block_traffic = 1 and o_intr_req = 0.
    - When the next sticky value is all-zero and there is no error event in that cycle, go to IDLE.
    - The first-error record clears in the same transition.
  - i_intr_ack outside INTR_PEND is ignored.
- Later errors (INTR_PEND or BLOCKED):
  - OR into sticky and increment the counter.
  - Do not update the first-error record or re-raise the interrupt.
- Latency:
  - Error pulse in cycle N gives sticky, first record, o_intr_req and o_block_traffic in cycle N+1.
  - CSR clear in cycle N updates sticky in N+1.
  - The FSM returns to IDLE with o_block_traffic=0 in N+1.
- Simultaneous events:
  - An error in the same cycle as a full clear in BLOCKED keeps the FSM in BLOCKED.
  - An error in the same cycle as ack in INTR_PEND goes to BLOCKED and the error is recorded.
- Softreset:
  - AFU softreset is not an input.
  - Errors persist across AFU softreset; only rst or CSR clear remove them.
- Reset mid-operation:
  - Asynchronous rst returns everything to reset values immediately.
  - This includes dropping o_intr_req without an ack.

Decomposition:
- Shared package prot_err_pkg holds:
  - the error-bit index localparams (MALFORMED_TLP=0, MAX_PAYLOAD=1, MAX_RD_REQ=2, MWR_INSUFF=3, MWR_OVERRUN=4, MMIO_INSUFF=5, MMIO_OVERRUN=6, MAX_TAG=7, MMIO_RD_RST=8, MMIO_WR_RST=9);
  - NUM_PROT_ERR=10;
  - the FSM enum prot_err_state_e.
- Sub-module: none required. The saturating counter and timestamp stay inline.

Test Plan:
- Error at timestamp 0x64: pulse bit 1 with i_vf_num=5 at counter 0x64 -> next cycle sticky=0x002, first_vf=5, first_ts=0x64, cnt=1, intr_req=1, block=1.
- Second error and ack: after the first error, pulse bit 7 with vf=9, then assert ack -> sticky=0x082, first record unchanged, cnt=2, FSM BLOCKED, intr_req=0.
- Partial then full clear: in BLOCKED with sticky=0x082, clr mask 0x002 -> sticky=0x080, block=1; clr mask 0x080 -> sticky=0, block=0, first record=0, FSM IDLE.
- Set/clear collision: clr mask 0x080 together with a bit-7 pulse in BLOCKED -> sticky stays 0x080, FSM stays BLOCKED.
- Masked and multi-bit errors: i_err_mask=0x001 and pulse 0x001 -> no change, cnt=0; pulse 0x3FF -> sticky=0x3FE, cnt=1.
- Counter saturation and reset: force cnt to 0xFFFF, pulse an error -> cnt stays 0xFFFF; assert rst while intr_req=1 -> all outputs 0 immediately.
